// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and the unpacked-operand type for the
// single-precision add/sub front end (fp_align_add, fp_align_shifter).
package fpu_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int GRS_W  = 3;
  localparam int EXT_W  = 27;   // hidden + fraction + guard/round/sticky
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic              hidden;
    logic [FRAC_W-1:0] frac;
  } fp_unpacked_t;

  // Zero exponent flushes the operand to zero (denormals are not supported).
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
    fp_unpacked_t u;
    u.sign   = x[31];
    u.exp    = x[30:23];
    u.hidden = (x[30:23] != '0);
    u.frac   = u.hidden ? x[22:0] : '0;
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// fp_align_shifter: combinational alignment shifter for the smaller operand.
// Ports:
//   ext_in  [26:0] in   {hidden, frac, 3'b000} of the smaller operand
//   shift   [7:0]  in   exponent difference
//   aligned [26:0] out  ext_in >> shift with shifted-out bits collapsed into
//                       bit 0 (sticky); shift >= 27 saturates to a lone sticky
module fp_align_shifter
  import fpu_pkg::*;
(
  input  logic [EXT_W-1:0] ext_in,
  input  logic [EXP_W-1:0] shift,
  output logic [EXT_W-1:0] aligned
);

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    shifted   = '0;
    lost_mask = '0;
    sticky    = 1'b0;
    aligned   = '0;
    if (shift >= EXP_W'(EXT_W)) begin
      aligned = {{(EXT_W-1){1'b0}}, |ext_in};
    end else begin
      shifted   = ext_in >> shift;
      lost_mask = ~({EXT_W{1'b1}} << shift);
      sticky    = |(ext_in & lost_mask);
      aligned   = {shifted[EXT_W-1:1], shifted[0] | sticky};
    end
  end

endmodule

// File: rtl/fp_align_add.sv
// fp_align_add: front end of the binary32 adder/subtractor. Stage 1 unpacks
// and orders the operands by magnitude, stage 2 aligns the smaller mantissa
// (with G/R/S) and performs the effective add or subtract. The registered
// outputs feed normalize_rounder directly.
// Ports:
//   clk, arst (async, active-high), en (0 = every register holds)
//   in_valid, a[31:0], b[31:0], op (0 = A+B, 1 = A-B)
//   out_valid, result_mant[26:0], carry_out, exp_result[7:0], result_sign,
//   a_sign, b_sign (raw), op_out  -- all aligned with the result
// Optional build macro FPU_SPECIAL_EN adds is_nan / is_inf outputs and
// Inf/NaN handling; without it exp=0xFF operands flow as ordinary numbers.
module fp_align_add
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  output logic [EXT_W-1:0] result_mant,
  output logic             carry_out,
  output logic [EXP_W-1:0] exp_result,
  output logic             result_sign,
  output logic             a_sign,
  output logic             b_sign,
  output logic             op_out
`ifdef FPU_SPECIAL_EN
  ,
  output logic             is_nan,
  output logic             is_inf
`endif
);

  // ---------------- stage 1: unpack / compare ----------------
  fp_unpacked_t ua, ub;
  logic         b_eff_sign;
  logic         eff_sub;
  logic         a_is_l;
  logic [30:0]  mag_a, mag_b;

  assign ua         = fp_unpack(a);
  assign ub         = fp_unpack(b);
  assign b_eff_sign = ub.sign ^ op;
  assign eff_sub    = ua.sign ^ b_eff_sign;
  assign mag_a      = {ua.exp, ua.frac};
  assign mag_b      = {ub.exp, ub.frac};
  assign a_is_l     = (mag_a >= mag_b);   // tie keeps A as the larger

  logic             s1_valid;
  logic [EXP_W-1:0] s1_exp_l;
  logic [EXP_W-1:0] s1_diff;
  logic [EXT_W-1:0] s1_ext_l;
  logic [EXT_W-1:0] s1_ext_s;
  logic             s1_eff_sub;
  logic             s1_sign_l;
  logic             s1_a_sign;
  logic             s1_b_sign;
  logic             s1_op;

`ifdef FPU_SPECIAL_EN
  logic a_nan, b_nan, a_inf, b_inf, nan_d;
  logic s1_nan, s1_inf;

  assign a_nan = (a[30:23] == EXP_MAX) && (a[22:0] != '0);
  assign b_nan = (b[30:23] == EXP_MAX) && (b[22:0] != '0);
  assign a_inf = (a[30:23] == EXP_MAX) && (a[22:0] == '0);
  assign b_inf = (b[30:23] == EXP_MAX) && (b[22:0] == '0);
  assign nan_d = a_nan | b_nan | (a_inf & b_inf & eff_sub);
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_valid   <= 1'b0;
      s1_exp_l   <= '0;
      s1_diff    <= '0;
      s1_ext_l   <= '0;
      s1_ext_s   <= '0;
      s1_eff_sub <= 1'b0;
      s1_sign_l  <= 1'b0;
      s1_a_sign  <= 1'b0;
      s1_b_sign  <= 1'b0;
      s1_op      <= 1'b0;
    end else if (en) begin
      s1_valid   <= in_valid;
      s1_eff_sub <= eff_sub;
      s1_a_sign  <= ua.sign;
      s1_b_sign  <= ub.sign;
      s1_op      <= op;
      if (a_is_l) begin
        s1_exp_l  <= ua.exp;
        s1_diff   <= ua.exp - ub.exp;
        s1_ext_l  <= {ua.hidden, ua.frac, {GRS_W{1'b0}}};
        s1_ext_s  <= {ub.hidden, ub.frac, {GRS_W{1'b0}}};
        s1_sign_l <= ua.sign;
      end else begin
        s1_exp_l  <= ub.exp;
        s1_diff   <= ub.exp - ua.exp;
        s1_ext_l  <= {ub.hidden, ub.frac, {GRS_W{1'b0}}};
        s1_ext_s  <= {ua.hidden, ua.frac, {GRS_W{1'b0}}};
        s1_sign_l <= b_eff_sign;
      end
    end
  end

`ifdef FPU_SPECIAL_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      s1_nan <= 1'b0;
      s1_inf <= 1'b0;
    end else if (en) begin
      s1_nan <= nan_d;
      s1_inf <= (a_inf | b_inf) & ~nan_d;
    end
  end
`endif

  // ---------------- stage 2: align / add ----------------
  logic [EXT_W-1:0] aligned;
  logic [EXT_W:0]   sum;
  logic [EXT_W-1:0] mant_d;
  logic [EXP_W-1:0] exp_d;
  logic             carry_d;
  logic             sign_d;

  fp_align_shifter u_shifter (
    .ext_in  (s1_ext_s),
    .shift   (s1_diff),
    .aligned (aligned)
  );

  always_comb begin
    sum     = '0;
    mant_d  = '0;
    exp_d   = s1_exp_l;
    carry_d = 1'b0;
    sign_d  = s1_sign_l;
    if (s1_eff_sub) begin
      // L >= S in magnitude, so the difference never goes negative.
      sum = {1'b0, s1_ext_l} - {1'b0, aligned};
    end else begin
      sum     = {1'b0, s1_ext_l} + {1'b0, aligned};
      carry_d = sum[EXT_W];
    end
    mant_d = sum[EXT_W-1:0];
    // x - x yields +0 regardless of the operand signs.
    if (s1_eff_sub && (sum[EXT_W-1:0] == '0)) sign_d = 1'b0;
`ifdef FPU_SPECIAL_EN
    if (s1_nan || s1_inf) begin
      exp_d  = EXP_MAX;
      mant_d = '0;
      if (s1_nan) mant_d[25] = 1'b1;   // quiet-NaN bit in the fraction MSB
    end
`endif
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      out_valid   <= 1'b0;
      result_mant <= '0;
      carry_out   <= 1'b0;
      exp_result  <= '0;
      result_sign <= 1'b0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      op_out      <= 1'b0;
    end else if (en) begin
      out_valid   <= s1_valid;
      result_mant <= mant_d;
      carry_out   <= carry_d;
      exp_result  <= exp_d;
      result_sign <= sign_d;
      a_sign      <= s1_a_sign;
      b_sign      <= s1_b_sign;
      op_out      <= s1_op;
    end
  end

`ifdef FPU_SPECIAL_EN
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      is_nan <= 1'b0;
      is_inf <= 1'b0;
    end else if (en) begin
      is_nan <= s1_nan;
      is_inf <= s1_inf;
    end
  end
`endif

endmodule

// File: tb/tb_fp_align_add.sv
// tb_fp_align_add: table-driven bench with a scoreboard queue for fp_align_add
// (default build, FPU_SPECIAL_EN undefined).
module tb_fp_align_add;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        en;
  logic        in_valid;
  logic [31:0] a, b;
  logic        op;
  logic        out_valid;
  logic [26:0] result_mant;
  logic        carry_out;
  logic [7:0]  exp_result;
  logic        result_sign;
  logic        a_sign, b_sign, op_out;

  fp_align_add #(.WIDTH(32)) dut (
    .clk         (clk),
    .arst        (arst),
    .en          (en),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .op          (op),
    .out_valid   (out_valid),
    .result_mant (result_mant),
    .carry_out   (carry_out),
    .exp_result  (exp_result),
    .result_sign (result_sign),
    .a_sign      (a_sign),
    .b_sign      (b_sign),
    .op_out      (op_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [26:0] mant;
    logic        carry;
    logic [7:0]  exp_v;
    logic        sign;
  } vec_t;

  typedef struct {
    logic [26:0] mant;
    logic        carry;
    logic [7:0]  exp_v;
    logic        sign;
    logic        as;
    logic        bs;
    logic        opv;
  } exp_t;

  localparam int NV = 15;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic drive(input vec_t v, input logic valid);
    exp_t e;
    a = v.a; b = v.b; op = v.op; in_valid = valid;
    if (valid && en) begin
      e = '{v.mant, v.carry, v.exp_v, v.sign, v.a[31], v.b[31], v.op};
      sb.push_back(e);
    end
  endtask

  // Advance one edge, sample 1 time unit later; a result is consumed only on
  // an edge where the pipeline actually advanced.
  task automatic tick();
    logic en_edge;
    exp_t e;
    en_edge = en;
    @(posedge clk);
    #1;
    if (en_edge && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'h0);
      end else begin
        e = sb.pop_front();
        check("result_mant", 32'(result_mant), 32'(e.mant));
        check("carry_out",   32'(carry_out),   32'(e.carry));
        check("exp_result",  32'(exp_result),  32'(e.exp_v));
        check("result_sign", 32'(result_sign), 32'(e.sign));
        check("a_sign",      32'(a_sign),      32'(e.as));
        check("b_sign",      32'(b_sign),      32'(e.bs));
        check("op_out",      32'(op_out),      32'(e.opv));
      end
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 8 && sb.size() > 0; k++) tick();
    check("drain_sb_empty", 32'(sb.size()), 32'h0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"},   32'(out_valid),   32'h0);
    check({tag, "_result_mant"}, 32'(result_mant), 32'h0);
    check({tag, "_carry_out"},   32'(carry_out),   32'h0);
    check({tag, "_exp_result"},  32'(exp_result),  32'h0);
    check({tag, "_result_sign"}, 32'(result_sign), 32'h0);
    check({tag, "_signs_op"},    32'({a_sign, b_sign, op_out}), 32'h0);
  endtask

  initial begin
    //            a             b             op    mant         carry exp    sign
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 27'h0000000, 1'b1, 8'h7F, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 27'h0000000, 1'b0, 8'h7F, 1'b0};
    vecs[2]  = '{32'h40000000, 32'h3F800000, 1'b1, 27'h2000000, 1'b0, 8'h80, 1'b0};
    vecs[3]  = '{32'h3F800000, 32'hC0000000, 1'b0, 27'h2000000, 1'b0, 8'h80, 1'b1};
    vecs[4]  = '{32'h3F800000, 32'h33800001, 1'b0, 27'h4000005, 1'b0, 8'h7F, 1'b0};
    vecs[5]  = '{32'h3F800000, 32'h2F800000, 1'b0, 27'h4000001, 1'b0, 8'h7F, 1'b0};
    vecs[6]  = '{32'h3F800000, 32'h33000000, 1'b0, 27'h4000002, 1'b0, 8'h7F, 1'b0};
    vecs[7]  = '{32'h3F800000, 32'h32800000, 1'b1, 27'h3FFFFFF, 1'b0, 8'h7F, 1'b0};
    vecs[8]  = '{32'h3F800000, 32'h33800001, 1'b1, 27'h3FFFFFB, 1'b0, 8'h7F, 1'b0};
    vecs[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 27'h7FFFFF0, 1'b1, 8'hFE, 1'b0};
    vecs[10] = '{32'hBF800000, 32'hBF800000, 1'b1, 27'h0000000, 1'b0, 8'h7F, 1'b0};
    vecs[11] = '{32'h80000000, 32'h00000000, 1'b1, 27'h0000000, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 27'h4000000, 1'b0, 8'h7F, 1'b0};
    vecs[13] = '{32'h3F800001, 32'hBF800002, 1'b0, 27'h0000008, 1'b0, 8'h7F, 1'b1};
    vecs[14] = '{32'h7F800000, 32'h7F800000, 1'b0, 27'h0000000, 1'b1, 8'hFF, 1'b0};

    arst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
    #22;
    check_zero_outputs("reset");
    arst = 1'b0;
    en   = 1'b1;
    tick();

    // Back-to-back stream of the vector table.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i], 1'b1);
      tick();
    end
    drain();
    tick();
    check("idle_out_valid", 32'(out_valid), 32'h0);

    // Stall: P reaches the outputs, X sits in stage 1 while en is low.
    drive(vecs[2], 1'b1);
    tick();
    drive(vecs[3], 1'b1);
    tick();
    en = 1'b0;
    drive(vecs[9], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_out_valid",   32'(out_valid),   32'h1);
      check("stall_result_mant", 32'(result_mant), 32'h2000000);
      check("stall_exp_result",  32'(exp_result),  32'h80);
      check("stall_result_sign", 32'(result_sign), 32'h0);
    end
    en = 1'b1;
    in_valid = 1'b0;
    tick();
    check("stall_release_sb_empty", 32'(sb.size()), 32'h0);
    tick();
    check("stall_bubble_out_valid", 32'(out_valid), 32'h0);

    // Asynchronous reset with W at the outputs and Y in stage 1.
    drive(vecs[9], 1'b1);
    tick();
    drive(vecs[4], 1'b1);
    tick();
    in_valid = 1'b0;
    #2 arst = 1'b1;
    #1;
    check_zero_outputs("arst");
    sb.delete();
    #2 arst = 1'b0;
    tick();
    check("post_arst_out_valid_1", 32'(out_valid), 32'h0);
    tick();
    check("post_arst_out_valid_2", 32'(out_valid), 32'h0);
    drive(vecs[5], 1'b1);
    tick();
    drain();
    tick();
    check("post_arst_idle_out_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
